// File: rtl/pc_update_unit_if.sv
// pc_update_unit_if: PC-source mux, branch, exception and vector-fetch signals of the PC stage
interface pc_update_unit_if;
  logic [2:0]  ctrl_pc_src;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [2:0]  pc_src_sel;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  exc_cause;
  logic        exc_busy;
  logic        vec_mem_read;
  logic [31:0] vec_addr;
  modport master (
    output ctrl_pc_src, pc_next, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt,
           exc_opcode, exc_overflow, exc_div0,
    input  pc_src_sel, pc, epc, exc_cause, exc_busy, vec_mem_read, vec_addr
  );
  modport slave (
    input  ctrl_pc_src, pc_next, pc_write, pc_write_cond, branch_op, alu_zero, alu_gt,
           exc_opcode, exc_overflow, exc_div0,
    output pc_src_sel, pc, epc, exc_cause, exc_busy, vec_mem_read, vec_addr
  );
endinterface

// File: rtl/pc_update_unit.sv
// pc_update_unit: holds PC/EPC, resolves branch writes and sequences exception vector fetch
module pc_update_unit (
  input logic              clk,
  input logic              reset,
  pc_update_unit_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SAVE, WAIT1, WAIT2, LOAD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        cond, exc_any;
  // Branch condition and exception detect from current inputs
  always_comb begin
    cond = bus.branch_op == 2'b00 ? bus.alu_zero :
           bus.branch_op == 2'b01 ? !bus.alu_zero :
           bus.branch_op == 2'b10 ? (bus.alu_zero | !bus.alu_gt) : bus.alu_gt;
    exc_any = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
  end
  // Next-state logic: PC writes only in IDLE, exceptions run SAVE->WAIT1->WAIT2->LOAD
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (bus.pc_write | (bus.pc_write_cond & cond)) pc_d = bus.pc_next;
        if (exc_any) begin
          state_d = SAVE;
          cause_d = bus.exc_opcode ? 2'b01 : bus.exc_overflow ? 2'b10 : 2'b11;
        end
      end
      SAVE: begin
        epc_d   = pc_q - 32'd4;
        state_d = WAIT1;
      end
      WAIT1: state_d = WAIT2;
      WAIT2: state_d = LOAD;
      LOAD: begin
        pc_d    = {24'b0, bus.pc_next[7:0]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end
  // Vector byte addresses 253..255 sit at 252 + cause
  always_comb begin
    bus.pc_src_sel   = state_q == LOAD ? 3'b100 : bus.ctrl_pc_src;
    bus.exc_busy     = state_q != IDLE;
    bus.vec_mem_read = state_q == SAVE;
    bus.vec_addr     = (state_q == SAVE || state_q == WAIT1 || state_q == WAIT2) ?
                       32'd252 + {30'b0, cause_q} : 32'd0;
  end
  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.exc_cause = cause_q;
endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Program-counter stage of the multicycle datapath, sitting directly downstream of the 5-way PC-source mux: it consumes the mux output, holds PC and EPC, resolves conditional-branch writes, and drives the mux selector. On an exception it overrides control, saves EPC, fetches the handler vector byte from memory and loads it into PC via the mux's MDR input, stalling the control unit meanwhile.

## Interface
- No parameters; widths fixed at 32-bit words, 3-bit selector.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- ctrl_pc_src  input  3  PC-source select requested by control (000 aluOut, 001 aluResult, 010 jump target, 011 EPC, 100 MDR)
- pc_next  input  32  PC-source mux output
- pc_write  input  1  unconditional PC write
- pc_write_cond  input  1  conditional PC write (branch)
- branch_op  input  2  00 beq, 01 bne, 10 ble, 11 bgt
- alu_zero  input  1  ALU zero flag
- alu_gt  input  1  ALU greater-than flag
- exc_opcode  input  1  nonexistent opcode, single-cycle pulse
- exc_overflow  input  1  arithmetic overflow, single-cycle pulse
- exc_div0  input  1  division by zero, single-cycle pulse
- pc_src_sel  output  3  selector to PC-source mux
- pc  output  32  program counter
- epc  output  32  exception PC (feeds mux EPC input)
- exc_cause  output  2  00 none, 01 opcode, 10 overflow, 11 div0
- exc_busy  output  1  exception sequence active; control must stall
- vec_mem_read  output  1  memory read request for vector byte
- vec_addr  output  32  vector address: 253 opcode, 254 overflow, 255 div0

## Operation
- Branch condition: beq = alu_zero; bne = !alu_zero; ble = alu_zero | !alu_gt; bgt = alu_gt.
- IDLE: pc <= pc_next when pc_write | (pc_write_cond & cond); pc_src_sel = ctrl_pc_src (combinational pass-through).
- Exception entry (IDLE only): any exc_* high -> SAVE. Priority when simultaneous: opcode > overflow > div0. Cause latched into exc_cause.
- SAVE (1 cycle): epc <= pc - 4 (32-bit wrap, pc=0 gives 0xFFFFFFFC); vec_mem_read=1; vec_addr per cause.
- WAIT1, WAIT2 (1 cycle each): memory latency and MDR capture; vec_addr held; vec_mem_read=0.
- LOAD (1 cycle): pc_src_sel forced to 100; pc <= {24'b0, pc_next[7:0]}; next state IDLE.
- exc_busy = 1 in SAVE, WAIT1, WAIT2, LOAD; pc_write / pc_write_cond ignored and exc_* pulses ignored (dropped, not queued) while busy.
- exc_cause retains its value after return to IDLE until next exception or reset.
- pc_src_sel forced to 100 only in LOAD; otherwise ctrl_pc_src.

## Timing
- Reset (sync): pc=0, epc=0, exc_cause=00, state IDLE, exc_busy=0, vec_mem_read=0, vec_addr=0; pc_src_sel = ctrl_pc_src.
- Reset asserted mid-sequence: next edge returns to IDLE with all reset values; no partial PC/EPC update from that edge.
- PC write latency: 1 cycle (pc valid the edge after write-enable sampled).
- Exception at edge N sampled -> SAVE in cycle N+1, LOAD in N+4, new pc visible N+5; exc_busy high exactly 4 cycles.
- Exception and pc_write in same IDLE cycle: pc write applies, exception also taken; EPC saves the updated pc - 4.
- vec_addr combinational from state and latched cause; 0 outside SAVE/WAIT1/WAIT2.

## Test plan
- Reset then pc_write=1, pc_next=0x00000004 -> pc=0x00000004 next cycle; pc_src_sel follows ctrl_pc_src=010.
- pc_write_cond=1, branch_op=00, alu_zero=0 -> pc unchanged; repeat with alu_zero=1, pc_next=0x40 -> pc=0x40; bgt with alu_gt=1 taken, ble with alu_gt=1 & zero=0 not taken.
- pc=0x20, exc_overflow pulse -> epc=0x1C, exc_cause=10, vec_addr=254 with vec_mem_read in SAVE, pc_src_sel=100 in LOAD, pc_next=0xABCDEF7C -> pc=0x0000007C, exc_busy 4 cycles.
- exc_opcode and exc_div0 same cycle -> exc_cause=01, vec_addr=253; exc_div0 pulse during WAIT1 ignored.
- pc_write=1 during busy -> pc unchanged until LOAD; pc=0 with exception -> epc=0xFFFFFFFC.
- reset asserted in WAIT2 -> pc=0, epc=0, exc_busy=0, exc_cause=00 next cycle.
